// File: rtl/qracc_csr.sv
// QRACC control/status register block.
// Two-state request/response slave on the controller bus: a request is
// committed on the IDLE->RESP edge and acknowledged with a one-cycle ready.
// Build option QRACC_CSR_READBACK_EN: when defined, CSR1..CSR6 read back their
// stored values; when undefined they read as zero (writes still take effect).

package qracc_pkg;

  typedef enum logic [2:0] {
    TRIGGER_IDLE            = 3'd0,
    TRIGGER_LOAD_SCALER     = 3'd1,
    TRIGGER_LOAD_ACTIVATION = 3'd2,
    TRIGGER_COMPUTE_ANALOG  = 3'd3,
    TRIGGER_COMPUTE_DIGITAL = 3'd4,
    TRIGGER_READ_ACC        = 3'd5,
    TRIGGER_WRITE_OUTPUT    = 3'd6,
    TRIGGER_RESERVED        = 3'd7
  } qracc_trigger_t;

  typedef struct packed {
    logic        binary_cfg;
    logic        unsigned_acts;
    logic [3:0]  adc_ref_range_shifts;
    logic [3:0]  filter_size_y;
    logic [3:0]  filter_size_x;
    logic [3:0]  stride_x;
    logic [3:0]  stride_y;
    logic [3:0]  n_input_bits_cfg;
    logic [3:0]  n_output_bits_cfg;
    logic [15:0] input_fmap_dimx;
    logic [15:0] input_fmap_dimy;
    logic [15:0] output_fmap_dimx;
    logic [15:0] output_fmap_dimy;
    logic [15:0] mapped_matrix_offset_x;
    logic [15:0] mapped_matrix_offset_y;
    logic [15:0] n_input_channels;
    logic [15:0] n_output_channels;
    logic [3:0]  padding;
    logic [7:0]  padding_value;
    logic        preserve_ifmap;
  } qracc_config_t;

endpackage

module qracc_csr
  import qracc_pkg::*;
(
  input  logic           clk,
  input  logic           nrst,
  input  logic [31:0]    ctrl_data_i,
  input  logic [31:0]    ctrl_addr_i,
  input  logic           ctrl_wen_i,
  input  logic           ctrl_valid_i,
  output logic           ctrl_ready_o,
  output logic [31:0]    ctrl_read_data_o,
  input  logic           busy_i,
  input  logic [3:0]     internal_state_i,
  output qracc_config_t  cfg_o,
  output qracc_trigger_t trigger_o,
  output logic           clear_o,
  output logic           inst_write_mode_o
);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t         state_q;
  logic           ready_q;
  logic [31:0]    rdata_q;
  qracc_trigger_t trigger_q;
  logic           clear_q;
  logic           err_q;
  logic           iwm_q;
  qracc_config_t  cfg_q;

  logic [2:0]     idx;
  logic           mapped;
  logic           trig_req;
  logic [31:0]    rd_word;
  logic           unused_addr;

  assign idx         = ctrl_addr_i[4:2];
  assign mapped      = (ctrl_addr_i[31:5] == '0) && (idx != 3'd7);
  assign trig_req    = (ctrl_data_i[2:0] != 3'd0);
  assign unused_addr = ^ctrl_addr_i[1:0];

  // Readback word for the addressed CSR, sampled at the commit edge.
  always_comb begin
    rd_word = '0;
    if (mapped) begin
      case (idx)
        3'd0: begin
          rd_word[4]    = busy_i;
          rd_word[5]    = iwm_q;
          rd_word[6]    = err_q;
          rd_word[11:8] = internal_state_i;
          rd_word[12]   = cfg_q.preserve_ifmap;
        end
`ifdef QRACC_CSR_READBACK_EN
        3'd1: rd_word = {cfg_q.n_output_bits_cfg, cfg_q.n_input_bits_cfg,
                         cfg_q.stride_y, cfg_q.stride_x,
                         cfg_q.filter_size_x, cfg_q.filter_size_y,
                         cfg_q.adc_ref_range_shifts, 2'b00,
                         cfg_q.unsigned_acts, cfg_q.binary_cfg};
        3'd2: rd_word = {cfg_q.input_fmap_dimy, cfg_q.input_fmap_dimx};
        3'd3: rd_word = {cfg_q.output_fmap_dimy, cfg_q.output_fmap_dimx};
        3'd4: rd_word = {cfg_q.mapped_matrix_offset_y, cfg_q.mapped_matrix_offset_x};
        3'd5: rd_word = {cfg_q.n_output_channels, cfg_q.n_input_channels};
        3'd6: rd_word = {20'd0, cfg_q.padding_value, cfg_q.padding};
`endif
        default: rd_word = '0;
      endcase
    end
  end

  // Handshake FSM, register commit and one-cycle response pulses.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q             <= S_IDLE;
      ready_q             <= 1'b0;
      rdata_q             <= '0;
      trigger_q           <= TRIGGER_IDLE;
      clear_q             <= 1'b0;
      err_q               <= 1'b0;
      iwm_q               <= 1'b0;
      cfg_q               <= '0;
      cfg_q.filter_size_x <= 4'd1;
      cfg_q.filter_size_y <= 4'd1;
      cfg_q.stride_x      <= 4'd1;
      cfg_q.stride_y      <= 4'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q   <= 1'b0;
          rdata_q   <= '0;
          trigger_q <= TRIGGER_IDLE;
          clear_q   <= 1'b0;
          if (ctrl_valid_i) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= ctrl_wen_i ? '0 : rd_word;
            if (ctrl_wen_i && mapped) begin
              if (idx == 3'd0) begin
                iwm_q                <= ctrl_data_i[5];
                cfg_q.preserve_ifmap <= ctrl_data_i[12];
                clear_q              <= ctrl_data_i[3];
                if (trig_req && !busy_i) begin
                  trigger_q <= qracc_trigger_t'(ctrl_data_i[2:0]);
                end
                // A clear in the same write overrides any error it raises.
                if (ctrl_data_i[3]) begin
                  err_q <= 1'b0;
                end else if (trig_req && busy_i) begin
                  err_q <= 1'b1;
                end
              end else if (busy_i) begin
                err_q <= 1'b1;
              end else begin
                case (idx)
                  3'd1: begin
                    cfg_q.binary_cfg           <= ctrl_data_i[0];
                    cfg_q.unsigned_acts        <= ctrl_data_i[1];
                    cfg_q.adc_ref_range_shifts <= ctrl_data_i[7:4];
                    cfg_q.filter_size_y        <= ctrl_data_i[11:8];
                    cfg_q.filter_size_x        <= ctrl_data_i[15:12];
                    cfg_q.stride_x             <= ctrl_data_i[19:16];
                    cfg_q.stride_y             <= ctrl_data_i[23:20];
                    cfg_q.n_input_bits_cfg     <= ctrl_data_i[27:24];
                    cfg_q.n_output_bits_cfg    <= ctrl_data_i[31:28];
                  end
                  3'd2: {cfg_q.input_fmap_dimy, cfg_q.input_fmap_dimx} <= ctrl_data_i;
                  3'd3: {cfg_q.output_fmap_dimy, cfg_q.output_fmap_dimx} <= ctrl_data_i;
                  3'd4: {cfg_q.mapped_matrix_offset_y, cfg_q.mapped_matrix_offset_x} <= ctrl_data_i;
                  3'd5: {cfg_q.n_output_channels, cfg_q.n_input_channels} <= ctrl_data_i;
                  3'd6: begin
                    cfg_q.padding       <= ctrl_data_i[3:0];
                    cfg_q.padding_value <= ctrl_data_i[11:4];
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          ready_q   <= 1'b0;
          rdata_q   <= '0;
          trigger_q <= TRIGGER_IDLE;
          clear_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctrl_ready_o      = ready_q;
  assign ctrl_read_data_o  = rdata_q;
  assign trigger_o         = trigger_q;
  assign clear_o           = clear_q;
  assign inst_write_mode_o = iwm_q;
  assign cfg_o             = cfg_q;

endmodule

// File: tb/tb_qracc_csr.sv
// Self-checking bench for qracc_csr: directed scenarios plus randomized bus
// traffic, checked every cycle against a word-level register model.
module tb_qracc_csr;
  import qracc_pkg::*;

`ifdef QRACC_CSR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic           clk;
  logic           nrst;
  logic [31:0]    ctrl_data;
  logic [31:0]    ctrl_addr;
  logic           ctrl_wen;
  logic           ctrl_valid;
  logic           ready;
  logic [31:0]    rdata;
  logic           busy;
  logic [3:0]     istate;
  qracc_config_t  cfg;
  qracc_trigger_t trig;
  logic           clr;
  logic           iwm;

  qracc_csr dut (
    .clk               (clk),
    .nrst              (nrst),
    .ctrl_data_i       (ctrl_data),
    .ctrl_addr_i       (ctrl_addr),
    .ctrl_wen_i        (ctrl_wen),
    .ctrl_valid_i      (ctrl_valid),
    .ctrl_ready_o      (ready),
    .ctrl_read_data_o  (rdata),
    .busy_i            (busy),
    .internal_state_i  (istate),
    .cfg_o             (cfg),
    .trigger_o         (trig),
    .clear_o           (clr),
    .inst_write_mode_o (iwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model (register words) ----------------
  logic [31:0] m_csr [1:6];
  logic        m_err, m_iwm, m_pres, m_resp, m_init;
  logic        m_ready, m_clr;
  logic [31:0] m_rd;
  logic [2:0]  m_trig;

  function automatic logic [31:0] wmask(input int unsigned k);
    if (k == 1) return 32'hFFFF_FFF3;
    if (k == 6) return 32'h0000_0FFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic qracc_config_t reset_cfg();
    qracc_config_t c;
    c = '0;
    c.filter_size_x = 4'd1;
    c.filter_size_y = 4'd1;
    c.stride_x      = 4'd1;
    c.stride_y      = 4'd1;
    return c;
  endfunction

  function automatic qracc_config_t model_cfg();
    qracc_config_t c;
    logic [31:0] w1, w2, w3, w4, w5, w6;
    w1 = m_csr[1]; w2 = m_csr[2]; w3 = m_csr[3];
    w4 = m_csr[4]; w5 = m_csr[5]; w6 = m_csr[6];
    c.binary_cfg             = w1[0];
    c.unsigned_acts          = w1[1];
    c.adc_ref_range_shifts   = w1[7:4];
    c.filter_size_y          = w1[11:8];
    c.filter_size_x          = w1[15:12];
    c.stride_x               = w1[19:16];
    c.stride_y               = w1[23:20];
    c.n_input_bits_cfg       = w1[27:24];
    c.n_output_bits_cfg      = w1[31:28];
    c.input_fmap_dimx        = w2[15:0];
    c.input_fmap_dimy        = w2[31:16];
    c.output_fmap_dimx       = w3[15:0];
    c.output_fmap_dimy       = w3[31:16];
    c.mapped_matrix_offset_x = w4[15:0];
    c.mapped_matrix_offset_y = w4[31:16];
    c.n_input_channels       = w5[15:0];
    c.n_output_channels      = w5[31:16];
    c.padding                = w6[3:0];
    c.padding_value          = w6[11:4];
    c.preserve_ifmap         = m_pres;
    return c;
  endfunction

  initial m_init = 1'b0;

  always @(posedge clk) begin
    int unsigned k;
    logic ok;
    if (!nrst) begin
      m_csr[1] = 32'h0011_1100;
      for (int i = 2; i <= 6; i++) m_csr[i] = '0;
      {m_err, m_iwm, m_pres, m_resp} = '0;
      {m_ready, m_clr} = '0;
      m_rd = '0; m_trig = '0; m_init = 1'b1;
    end else if (m_init) begin
      m_ready = 1'b0; m_clr = 1'b0; m_rd = '0; m_trig = '0;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (ctrl_valid) begin
        m_resp = 1'b1;
        m_ready = 1'b1;
        k = ctrl_addr[4:2];
        ok = (ctrl_addr[31:5] == 0) && (k != 7);
        if (!ctrl_wen) begin
          if (ok && k == 0)
            m_rd = (32'(m_pres) << 12) | (32'(istate) << 8) | (32'(m_err) << 6)
                 | (32'(m_iwm) << 5) | (32'(busy) << 4);
          else if (ok && RB)
            m_rd = m_csr[k];
        end else if (ok) begin
          if (k == 0) begin
            m_iwm  = ctrl_data[5];
            m_pres = ctrl_data[12];
            if (ctrl_data[2:0] != 0) begin
              if (busy) m_err = 1'b1;
              else m_trig = ctrl_data[2:0];
            end
            if (ctrl_data[3]) begin
              m_clr = 1'b1;
              m_err = 1'b0;
            end
          end else if (busy) begin
            m_err = 1'b1;
          end else begin
            m_csr[k] = ctrl_data & wmask(k);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("ready", ready, m_ready);
      check("rdata", rdata, m_rd);
      check("trigger", trig, m_trig);
      check("clear", clr, m_clr);
      check("inst_write_mode", iwm, m_iwm);
      check("cfg", cfg, model_cfg());
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic [2:0] tg, output logic cl);
    int unsigned cyc;
    bit got;
    @(posedge clk); #1;
    ctrl_valid = 1'b1; ctrl_wen = w; ctrl_addr = a; ctrl_data = d;
    got = 0; cyc = 0; rd = '0; tg = '0; cl = 1'b0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (ready === 1'b1) begin
        got = 1; rd = rdata; tg = trig; cl = clr;
      end
    end
    check("ready_seen", got, 1'b1);
    check("ready_latency", cyc, 1);
    ctrl_valid = 1'b0;
    ctrl_wen = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  tg;
    logic        cl;
    logic [31:0] a, d;
    nrst = 1'b0; ctrl_valid = 1'b0; ctrl_wen = 1'b0;
    ctrl_addr = '0; ctrl_data = '0; busy = 1'b0; istate = 4'h0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // Reset state pins
    check("rst_ready", ready, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_trigger", trig, TRIGGER_IDLE);
    check("rst_iwm", iwm, 1'b0);
    check("rst_cfg", cfg, reset_cfg());

    xact(1'b0, 32'h4, 32'h0, rd, tg, cl);
    check("rst_csr1_read", rd, RB ? 32'h0011_1100 : 32'h0);

    // Trigger on an idle controller
    busy = 1'b0;
    xact(1'b1, 32'h0, 32'h0000_0003, rd, tg, cl);
    check("trigger_analog", tg, TRIGGER_COMPUTE_ANALOG);
    @(posedge clk); #1;
    check("trigger_one_cycle", trig, TRIGGER_IDLE);
    xact(1'b0, 32'h0, 32'h0, rd, tg, cl);
    check("csr0_trigger_reads_0", rd[2:0], 3'd0);

    // Dropped config write while busy, then clear
    busy = 1'b1;
    xact(1'b1, 32'h8, 32'h0020_0010, rd, tg, cl);
    busy = 1'b0;
    check("busy_write_dropped", cfg.input_fmap_dimx, 16'h0);
    xact(1'b0, 32'h0, 32'h0, rd, tg, cl);
    check("err_set", rd[6], 1'b1);
    xact(1'b1, 32'h0, 32'h0000_0008, rd, tg, cl);
    check("clear_pulse", cl, 1'b1);
    xact(1'b0, 32'h0, 32'h0, rd, tg, cl);
    check("err_cleared", rd[6], 1'b0);

    // Padding register and unmapped index
    xact(1'b1, 32'h18, 32'h0000_0FF1, rd, tg, cl);
    check("padding", cfg.padding, 4'h1);
    check("padding_value", cfg.padding_value, 8'hFF);
    xact(1'b0, 32'h18, 32'h0, rd, tg, cl);
    check("csr6_read", rd, RB ? 32'h0000_0FF1 : 32'h0);
    xact(1'b0, 32'h1C, 32'h0, rd, tg, cl);
    check("unmapped_read", rd, 32'h0);

    xact(1'b1, 32'hC, 32'h1234_5678, rd, tg, cl);
    check("ofmap_dimx", cfg.output_fmap_dimx, 16'h5678);
    xact(1'b0, 32'hC, 32'h0, rd, tg, cl);
    check("csr3_read", rd, RB ? 32'h1234_5678 : 32'h0);

    // Reset during the response cycle
    @(posedge clk); #1;
    ctrl_valid = 1'b1; ctrl_wen = 1'b1; ctrl_addr = 32'h10; ctrl_data = 32'hABCD_1234;
    @(posedge clk); #1;
    check("abort_ready_before", ready, 1'b1);
    check("abort_cfg_written", cfg.mapped_matrix_offset_x, 16'h1234);
    nrst = 1'b0; ctrl_valid = 1'b0; ctrl_wen = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", ready, 1'b0);
    check("abort_cfg", cfg, reset_cfg());
    check("abort_trigger", trig, TRIGGER_IDLE);
    check("abort_clear", clr, 1'b0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      busy   = ($urandom_range(0, 2) == 0);
      istate = 4'($urandom);
      a = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) a[31:5] = 27'($urandom) | 27'd1;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d[3] = 1'b0;
      xact(1'($urandom), a, d, rd, tg, cl);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
